// File: rtl/mult_hilo_unit.sv
// HI/LO sequencer for a pipelined 32x32 multiplier: converts signed operands to magnitudes,
// holds them on the multiplier for LATENCY edges, then captures (and re-signs) the product.
module mult_hilo_unit #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        start,
  input  logic        op_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [63:0] prod;
  logic [63:0] prod_signed;

  assign prod        = {mul_hi, mul_lo};
  // Magnitudes are at most 2^31 each, so negating the 64-bit product is exact.
  assign prod_signed = neg_q ? (~prod + 64'd1) : prod;

  // Next-state: accept requests/writes in idle, count and capture in busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start) begin
          // 0x80000000 negates to itself, which is the correct unsigned magnitude.
          mul_a_d = (op_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
          mul_b_d = (op_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
          neg_d   = op_signed & (op_a[31] ^ op_b[31]);
          cnt_d   = 4'd1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 4'd1;
        if (flush) begin
          // Abort wins over a coincident capture edge.
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else if (cnt_q == 4'(LATENCY)) begin
          hi_d    = prod_signed[63:32];
          lo_d    = prod_signed[31:0];
          done_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      neg_q   <= 1'b0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Outputs are decoded purely from registered state.
  always_comb begin
    ready = (state_q == StIdle);
    busy  = (state_q == StBusy);
    done  = done_q;
    mul_a = mul_a_q;
    mul_b = mul_b_q;
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Self-checking bench for mult_hilo_unit with a behavioural pipelined multiplier and a
// scoreboard of expected {hi,lo} results.
module tb_mult_hilo_unit;

  localparam int unsigned Lat = 4;

  logic        clock = 1'b0;
  logic        nreset, start, op_signed, flush, wr_hi, wr_lo;
  logic [31:0] op_a, op_b, wdata, mul_a, mul_b, mul_hi, mul_lo, hi, lo;
  logic        ready, busy, done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] arch_hi, arch_lo;

  mult_hilo_unit #(.LATENCY(Lat)) dut (
    .clock(clock), .nreset(nreset), .start(start), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wdata(wdata), .mul_a(mul_a), .mul_b(mul_b), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .ready(ready), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // Multiplier model: operands registered at the accepting edge count as the first of the
  // LATENCY edges, so the product appears after Lat-1 further register stages.
  logic [63:0] pipe [Lat-1];
  always @(posedge clock) begin
    pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
    for (int i = 1; i < Lat - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign {mul_hi, mul_lo} = pipe[Lat-2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] mag(input bit s, input logic [31:0] v);
    return (s && v[31]) ? 32'd0 - v : v;
  endfunction

  task automatic check_reset();
    check_val("rst_hi", hi, 0);
    check_val("rst_lo", lo, 0);
    check_val("rst_mul_a", mul_a, 0);
    check_val("rst_mul_b", mul_b, 0);
    check_val("rst_ready", ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
  endtask

  task automatic write_reg(input bit is_hi, input logic [31:0] v);
    wr_hi = is_hi; wr_lo = !is_hi; wdata = v;
    step();
    wr_hi = 0; wr_lo = 0;
    if (is_hi) arch_hi = v; else arch_lo = v;
    check_val(is_hi ? "wr_hi" : "wr_lo", {hi, lo}, {arch_hi, arch_lo});
  endtask

  // mode: 0 plain, 1 start/write hazards while busy, 2 start together with wr_lo.
  // Returns in the done cycle so the caller may issue back-to-back.
  task automatic run_mul(input bit s, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [31:0] ma, mb;
    logic [63:0] e;
    int n;
    ma = mag(s, a); mb = mag(s, b);
    check_val("ready_pre", ready, 1);
    op_signed = s; op_a = a; op_b = b; start = 1;
    if (mode == 2) begin wr_lo = 1; wdata = 32'h77; end
    exp_q.push_back(model(s, a, b));
    step();
    start = 0; wr_lo = 0;
    if (mode == 2) begin
      arch_lo = 32'h77;
      check_val("start_wr_lo", lo, arch_lo);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      check_val("mul_a_hold", mul_a, ma);
      check_val("mul_b_hold", mul_b, mb);
      if (mode == 1 && n == 1) begin
        start = 1; op_a = a ^ 32'h1111; wr_hi = 1; wdata = 32'h1234;
      end
      step();
      start = 0; wr_hi = 0;
      n++;
      if (mode == 1 && n == 2) check_val("busy_wr_hi_ignored", hi, arch_hi);
    end
    check_val("busy_cycles", n, Lat);
    check_val("done_pulse", done, 1);
    check_val("ready_done", ready, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("product", {hi, lo}, e);
      {arch_hi, arch_lo} = e;
    end else begin
      check_val("scoreboard_empty", 1, 0);
    end
  endtask

  task automatic step_check_done_low();
    step();
    check_val("done_one_cycle", done, 0);
  endtask

  initial begin
    nreset = 0; start = 0; op_signed = 0; op_a = 0; op_b = 0; flush = 0;
    wr_hi = 0; wr_lo = 0; wdata = 0; arch_hi = 0; arch_lo = 0;
    step(); step();
    check_reset();
    nreset = 1;

    write_reg(1, 32'hDEADBEEF);
    write_reg(0, 32'h1);

    run_mul(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check_val("tp_unsigned", {hi, lo}, 64'hFFFFFFFE_00000001);
    step_check_done_low();

    run_mul(1, 32'hFFFFFFFD, 32'd5, 0);
    check_val("tp_signed", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    step_check_done_low();

    run_mul(1, 32'h80000000, 32'h80000000, 1);
    check_val("tp_min_min", {hi, lo}, 64'h40000000_00000000);
    run_mul(1, 32'h80000000, 32'd1, 0);   // issued in the done cycle
    check_val("tp_min_one", {hi, lo}, 64'hFFFFFFFF_80000000);
    step_check_done_low();

    for (int i = 0; i < 4; i++) begin
      run_mul(1'($urandom_range(0, 1)), $urandom, $urandom, 0);
      step_check_done_low();
    end

    run_mul(0, 32'h00010000, 32'h00030000, 2);
    step_check_done_low();

    // Flush at cnt=2 keeps HI/LO.
    write_reg(1, 32'hAAAA0000);
    write_reg(0, 32'h5555);
    op_signed = 0; op_a = 32'h7; op_b = 32'h9; start = 1;
    step(); start = 0;
    step();
    flush = 1;
    step(); flush = 0;
    check_val("flush_ready", ready, 1);
    check_val("flush_busy", busy, 0);
    check_val("flush_done", done, 0);
    check_val("flush_hilo", {hi, lo}, {arch_hi, arch_lo});
    step();
    check_val("flush_done_later", done, 0);

    // Flush coinciding with the capture edge.
    start = 1;
    step(); start = 0;
    step(); step(); step();
    flush = 1;
    step(); flush = 0;
    check_val("flush_cap_done", done, 0);
    check_val("flush_cap_hilo", {hi, lo}, {arch_hi, arch_lo});
    check_val("flush_cap_ready", ready, 1);

    run_mul(1, 32'd12345, 32'hFFFFFF00, 0);
    step_check_done_low();

    // Reset mid-operation.
    op_signed = 0; op_a = 32'h1234_5678; op_b = 32'h9; start = 1;
    step(); start = 0;
    step();
    nreset = 0;
    step();
    nreset = 1;
    check_reset();
    step();
    check_val("rst_stays_idle", {31'd0, ready, 31'd0, done}, {31'd0, 1'b1, 32'd0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_hilo_unit.md
# mult_hilo_unit

Sequencer and HI/LO register file placed directly downstream of the pipelined 32x32 unsigned multiplier. It accepts a multiply request from the execute stage and, for signed requests, converts the operands to magnitudes. It holds those operands stable on the multiplier inputs for the full pipeline latency, then captures the 64-bit product into architectural HI/LO registers, negating it when the request was signed with operands of opposite sign. It also services direct HI/LO writes (MTHI/MTLO) and gives the pipeline a busy signal for stalling HI/LO reads.

## Interface

- LATENCY, 4, clock edges from operands being valid on mul_a/mul_b to a valid product on mul_hi/mul_lo; legal range 1..15.

- clock  input  1  system clock; all state updates on the rising edge.
- nreset  input  1  synchronous, active-low reset.
- start  input  1  request a multiply; accepted only when ready=1.
- op_signed  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start.
- op_a  input  32  multiplicand; sampled with start.
- op_b  input  32  multiplier; sampled with start.
- flush  input  1  abort the multiply in flight.
- wr_hi  input  1  write wdata into HI.
- wr_lo  input  1  write wdata into LO.
- wdata  input  32  data for wr_hi/wr_lo.
- mul_a  output  32  operand A driven to the multiplier (registered).
- mul_b  output  32  operand B driven to the multiplier (registered).
- mul_hi  input  32  product bits 63:32 returned by the multiplier.
- mul_lo  input  32  product bits 31:0 returned by the multiplier.
- ready  output  1  1 in IDLE.
- busy  output  1  1 in BUSY; the pipeline stalls MFHI/MFLO while it is high.
- done  output  1  one-cycle pulse in the cycle after HI/LO take a product.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

## Operation

- Two states: IDLE and BUSY. A 4-bit counter cnt runs in BUSY.
- IDLE, start=1:
  - mul_a ← op_signed&op_a[31] ? −op_a : op_a.
  - mul_b ← op_signed&op_b[31] ? −op_b : op_b.
  - neg ← op_signed&(op_a[31]^op_b[31]).
  - cnt ← 1; go to BUSY.
- Magnitude of 0x80000000 is 0x80000000, read as unsigned. The product of magnitudes is ≤2^62, so the negated 64-bit result is exact.
- BUSY:
  - mul_a/mul_b are held unchanged throughout. The multiplier mixes pipeline stages internally and requires stable inputs.
  - cnt ← cnt+1 on each edge.
  - On the edge where cnt==LATENCY: {hi,lo} ← neg ? −{mul_hi,mul_lo} (64-bit two's complement) : {mul_hi,mul_lo}; go to IDLE; done ← 1 for the following cycle.
- flush=1 in BUSY: go to IDLE. HI/LO are unchanged and done is not asserted. flush in IDLE has no effect.
- wr_hi/wr_lo:
  - In IDLE they take effect on the same edge; hi/lo show wdata in the next cycle.
  - In BUSY they are ignored. The issuing stage is responsible for stalling them.
- start while BUSY is ignored and no request is queued.
- start together with wr_hi/wr_lo in IDLE: both are applied. The write lands immediately and is overwritten by the product LATENCY edges later.
- flush and the capture edge in the same cycle: flush wins, and HI/LO are unchanged.
- All arithmetic is unsigned modular at the stated widths. There is no overflow signalling.

## Timing

- Reset (nreset=0 at an edge): state IDLE; cnt=0; neg=0; mul_a=mul_b=0; hi=lo=0; done=0; ready=1; busy=0. Reset mid-operation discards the operation.
- Start accepted at edge E0:
  - busy=1 from after E0 until after edge E0+LATENCY.
  - The new hi/lo and done=1 are visible in the cycle after edge E0+LATENCY.
  - ready=1 in that same cycle, so back-to-back issue gives one multiply per LATENCY+1 cycles.
- ready, busy and done are decoded from registered state, with no combinational path from any input.
- hi and lo change only on the capture edge, on an accepted write, or on reset.

## Test plan

- Unsigned, LATENCY=4: op_a=op_b=0xFFFFFFFF → busy for exactly 4 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done high for 1 cycle.
- Signed: −3 (0xFFFFFFFD) × 5 → mul_a=3, mul_b=5; result hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed boundary: 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000. Also 0x80000000 × 1 → hi=0xFFFFFFFF, lo=0x80000000.
- Hazards: start while busy, with a different op_a → ignored; mul_a stays stable every BUSY cycle. wr_hi=1, wdata=0x1234 while busy → hi unchanged. A second start in the done cycle is accepted.
- Abort: flush at cnt=2 with prior hi/lo=0xAAAA0000/0x5555 → values retained, no done pulse, ready next cycle.
- Reset and writes: nreset low mid-BUSY → all outputs at reset values next cycle. In IDLE, wr_hi (wdata=0xDEADBEEF) then wr_lo (wdata=0x1) → hi=0xDEADBEEF, lo=0x1 one cycle after each write.
